// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg
// Shared definitions for the instruction-fetch slice: the fetch state
// encoding, default address/instruction widths, the reset PC and the
// sequential PC increment. Also provides a target-alignment helper.
package cpu_fetch_pkg;

    localparam int CPU_XLEN = 64;
    localparam int CPU_ILEN = 32;

    localparam logic [CPU_XLEN-1:0] RESET_PC_DEFAULT = 64'h0;

    // Every instruction is one 32-bit word, so sequential fetch advances by 4.
    localparam int PC_INC = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FAULT
    } fetch_state_t;

    // A fetch target is legal only if it is word aligned.
    function automatic logic is_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// fetch_controller_if
// Bundles the two buses of the fetch controller:
//   - InstructionMemory bus: imem_addr (to memory), imem_instr (from memory)
//   - decode handshake: if_valid/if_pc/if_instr (to decode), if_ready (from decode)
// master = fetch controller side, slave = memory/decode side.
interface fetch_controller_if
    import cpu_fetch_pkg::*;
#(
    parameter int XLEN = CPU_XLEN,
    parameter int ILEN = CPU_ILEN
);

    logic [XLEN-1:0] imem_addr;
    logic [ILEN-1:0] imem_instr;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [ILEN-1:0] if_instr;

    modport master (
        output imem_addr,
        output if_valid,
        output if_pc,
        output if_instr,
        input  imem_instr,
        input  if_ready
    );

    modport slave (
        input  imem_addr,
        input  if_valid,
        input  if_pc,
        input  if_instr,
        output imem_instr,
        output if_ready
    );

endinterface

// File: rtl/fetch_controller_buffer.sv
// fetch_buffer
// Small circular FIFO of {pc, instr} pairs sitting between the instruction
// memory response and decode.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   flush             drop all entries (wins over push and pop)
//   push, push_pc,
//   push_instr        write one entry at the tail
//   pop               remove the head entry
//   count             number of valid entries
//   empty             no valid entries
//   head_pc,
//   head_instr        contents of the head entry
module fetch_buffer
    import cpu_fetch_pkg::*;
#(
    parameter int XLEN  = CPU_XLEN,
    parameter int ILEN  = CPU_ILEN,
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic [ILEN-1:0] push_instr,
    input  logic            pop,
    output logic [CW-1:0]   count,
    output logic            empty,
    output logic [XLEN-1:0] head_pc,
    output logic [ILEN-1:0] head_instr
);

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [ILEN-1:0] instr_mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    // Storage is cleared on reset so the head reads as zero until the
    // first real entry arrives. DEPTH is a power of two, so the pointers
    // wrap naturally. The controller's credit check guarantees push never
    // lands on a full buffer and pop is only requested when non-empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= push_pc;
                instr_mem[wr_ptr] <= push_instr;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign empty      = (count == '0);
    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller
// Instruction-fetch sequencer. Owns the fetch PC, issues one address per
// cycle to a synchronous instruction memory (one-cycle read latency),
// buffers the returned words and presents {pc, instr} to decode over a
// valid/ready handshake. Redirects flush everything in flight; misaligned
// targets park the sequencer in FAULT until an aligned redirect arrives.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             leave IDLE and begin fetching from the current pc
//   redirect_valid,
//   redirect_pc       taken branch/jump and its target
//   fault, fault_pc   misaligned-target trap and the offending target
//   bus (master)      imem_addr/imem_instr and if_valid/if_ready/if_pc/if_instr
module fetch_controller
    import cpu_fetch_pkg::*;
#(
    parameter int              XLEN      = CPU_XLEN,
    parameter int              ILEN      = CPU_ILEN,
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               fault,
    output logic [XLEN-1:0]    fault_pc,
    fetch_controller_if.master bus
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic            inflight, inflight_next;
    logic [XLEN-1:0] inflight_pc, inflight_pc_next;
    logic [XLEN-1:0] fault_pc_next;

    logic            pop_req;
    logic            buf_push;
    logic            buf_pop;
    logic [CW-1:0]   buf_count;
    logic            buf_empty;
    logic [CW:0]     credit_used;
    logic            target_ok;

    fetch_buffer #(
        .XLEN  (XLEN),
        .ILEN  (ILEN),
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (buf_push),
        .push_pc    (inflight_pc),
        .push_instr (bus.imem_instr),
        .pop        (buf_pop),
        .count      (buf_count),
        .empty      (buf_empty),
        .head_pc    (bus.if_pc),
        .head_instr (bus.if_instr)
    );

    // A redirect flushes the buffer, so neither the returning word nor the
    // decode handshake may touch it in that cycle.
    assign pop_req  = bus.if_valid & bus.if_ready;
    assign buf_pop  = pop_req & ~redirect_valid;
    assign buf_push = inflight & ~redirect_valid;

    // Slots already spoken for: buffered entries plus the word still in the
    // memory pipe, minus the one decode takes this cycle. Issuing only while
    // this is below the depth means a response always has a slot waiting.
    assign credit_used = {1'b0, buf_count}
                       + {{CW{1'b0}}, inflight}
                       - {{CW{1'b0}}, pop_req};

    assign target_ok = is_aligned(redirect_pc[1:0]);

    // State and fetch-pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            fault_pc    <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            inflight    <= inflight_next;
            inflight_pc <= inflight_pc_next;
            fault_pc    <= fault_pc_next;
        end
    end

    // Next-state logic. A redirect always wins over issue. In IDLE a
    // redirect only preloads the pc; a misaligned target there is simply
    // not loaded, since nothing is being fetched that could trap.
    // inflight defaults low so it is set only in the cycle an address issues.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        inflight_next    = 1'b0;
        inflight_pc_next = inflight_pc;
        fault_pc_next    = fault_pc;

        case (state)
            IDLE: begin
                if (redirect_valid) begin
                    if (target_ok) begin
                        pc_next = redirect_pc;
                    end
                end else if (start) begin
                    state_next = FETCH;
                end
            end

            FETCH: begin
                if (redirect_valid) begin
                    if (target_ok) begin
                        pc_next = redirect_pc;
                    end else begin
                        state_next    = FAULT;
                        fault_pc_next = redirect_pc;
                    end
                end else if (credit_used < (CW+1)'(BUF_DEPTH)) begin
                    inflight_next    = 1'b1;
                    inflight_pc_next = pc;
                    pc_next          = pc + XLEN'(PC_INC);
                end
            end

            FAULT: begin
                if (redirect_valid) begin
                    if (target_ok) begin
                        pc_next    = redirect_pc;
                        state_next = FETCH;
                    end else begin
                        fault_pc_next = redirect_pc;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The memory address is the pc register itself, never a combinational
    // function of this cycle's inputs.
    assign bus.imem_addr = pc;
    assign bus.if_valid  = ~buf_empty;
    assign fault         = (state == FAULT);

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller
// Directed bench for fetch_controller. A behavioural instruction memory
// returns {16'hA5A5, addr[15:0]} one cycle after the address. Inputs are
// driven and outputs compared on the falling clock edge.
module tb_fetch_controller;
    import cpu_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fault;
    logic [63:0] fault_pc;

    int vectors     = 0;
    int miscompares = 0;

    fetch_controller_if #(.XLEN(64), .ILEN(32)) bus ();

    fetch_controller #(
        .XLEN      (64),
        .ILEN      (32),
        .RESET_PC  (64'h0),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory with a recognisable data pattern.
    initial bus.imem_instr = 32'h0;
    always @(posedge clk) begin
        bus.imem_instr <= {16'hA5A5, bus.imem_addr[15:0]};
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_head(input string tag, input logic [63:0] exp_pc,
                              input logic [31:0] exp_instr);
        check_output({tag, ".valid"}, {63'h0, bus.if_valid}, 64'h1);
        check_output({tag, ".pc"}, bus.if_pc, exp_pc);
        check_output({tag, ".instr"}, {32'h0, bus.if_instr}, {32'h0, exp_instr});
    endtask

    task automatic check_empty(input string tag, input logic [63:0] exp_addr);
        check_output({tag, ".valid"}, {63'h0, bus.if_valid}, 64'h0);
        check_output({tag, ".addr"}, bus.imem_addr, exp_addr);
    endtask

    task automatic apply_stimulus(input logic st, input logic rv, input logic [63:0] rp,
                                  input logic rdy);
        @(negedge clk);
        start          = st;
        redirect_valid = rv;
        redirect_pc    = rp;
        bus.if_ready   = rdy;
    endtask

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        bus.if_ready   = 1'b0;

        $display("[TB] reset values");
        @(negedge clk);
        check_empty("rst", 64'h0);
        check_output("rst.if_pc", bus.if_pc, 64'h0);
        check_output("rst.if_instr", {32'h0, bus.if_instr}, 64'h0);
        check_output("rst.fault", {63'h0, fault}, 64'h0);
        check_output("rst.fault_pc", fault_pc, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] startup latency and streaming");
        apply_stimulus(1'b1, 1'b0, 64'h0, 1'b1);          // cycle 0
        check_empty("c0", 64'h0);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);          // cycle 1
        check_empty("c1", 64'h0);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);          // cycle 2
        check_empty("c2", 64'h4);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);          // cycle 3
        check_head("c3", 64'h0, 32'hA5A50000);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);          // cycle 4
        check_head("c4", 64'h4, 32'hA5A50004);

        $display("[TB] backpressure");
        for (int i = 0; i < 6; i++) begin                 // cycles 5..10
            apply_stimulus(1'b0, 1'b0, 64'h0, 1'b0);
            check_head("stall", 64'h8, 32'hA5A50008);
            check_output("stall.addr", bus.imem_addr, 64'h10);
        end
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);          // cycle 11
        check_head("c11", 64'h8, 32'hA5A50008);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);          // cycle 12
        check_head("c12", 64'hC, 32'hA5A5000C);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);          // cycle 13
        check_head("c13", 64'h10, 32'hA5A50010);

        $display("[TB] redirect flush");
        apply_stimulus(1'b0, 1'b1, 64'h100, 1'b1);        // cycle 14
        check_head("c14", 64'h14, 32'hA5A50014);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);          // cycle 15
        check_empty("c15", 64'h100);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);          // cycle 16
        check_empty("c16", 64'h104);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);          // cycle 17
        check_head("c17", 64'h100, 32'hA5A50100);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);          // cycle 18
        check_head("c18", 64'h104, 32'hA5A50104);

        $display("[TB] misaligned target");
        apply_stimulus(1'b0, 1'b1, 64'h102, 1'b1);        // cycle 19
        check_head("c19", 64'h108, 32'hA5A50108);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);          // cycle 20
        check_empty("c20", 64'h110);
        check_output("c20.fault", {63'h0, fault}, 64'h1);
        check_output("c20.fault_pc", fault_pc, 64'h102);
        apply_stimulus(1'b0, 1'b1, 64'h103, 1'b1);        // cycle 21
        check_empty("c21", 64'h110);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);          // cycle 22
        check_empty("c22", 64'h110);
        check_output("c22.fault", {63'h0, fault}, 64'h1);
        check_output("c22.fault_pc", fault_pc, 64'h103);
        apply_stimulus(1'b0, 1'b1, 64'h200, 1'b1);        // cycle 23
        check_output("c23.fault", {63'h0, fault}, 64'h1);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);          // cycle 24
        check_empty("c24", 64'h200);
        check_output("c24.fault", {63'h0, fault}, 64'h0);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);          // cycle 25
        check_empty("c25", 64'h204);

        $display("[TB] address wrap");
        apply_stimulus(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);  // cycle 26
        check_head("c26", 64'h200, 32'hA5A50200);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);          // cycle 27
        check_empty("c27", 64'hFFFF_FFFF_FFFF_FFF8);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);          // cycle 28
        check_empty("c28", 64'hFFFF_FFFF_FFFF_FFFC);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);          // cycle 29
        check_head("c29", 64'hFFFF_FFFF_FFFF_FFF8, 32'hA5A5FFF8);
        check_output("c29.addr", bus.imem_addr, 64'h0);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);          // cycle 30
        check_head("c30", 64'hFFFF_FFFF_FFFF_FFFC, 32'hA5A5FFFC);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);          // cycle 31
        check_head("c31", 64'h0, 32'hA5A50000);

        $display("[TB] asynchronous reset mid-stream");
        #2 reset = 1'b1;
        #1;
        check_empty("arst", 64'h0);
        check_output("arst.if_pc", bus.if_pc, 64'h0);
        check_output("arst.if_instr", {32'h0, bus.if_instr}, 64'h0);
        check_output("arst.fault", {63'h0, fault}, 64'h0);
        check_output("arst.fault_pc", fault_pc, 64'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] redirect while idle, then restart");
        apply_stimulus(1'b0, 1'b1, 64'h40, 1'b1);         // idle preload
        check_empty("r0", 64'h0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);
            check_empty("idle", 64'h40);
        end
        apply_stimulus(1'b1, 1'b0, 64'h0, 1'b1);          // restart cycle 0
        check_empty("s0", 64'h40);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);
        check_empty("s1", 64'h40);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);
        check_empty("s2", 64'h44);
        apply_stimulus(1'b0, 1'b0, 64'h0, 1'b1);
        check_head("s3", 64'h40, 32'hA5A50040);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
